reflex_arbiter: RTL
===================

# reflex_arbiter

Multi-player round scheduler for the reflex tester. Shares the single reaction-timing datapath (random-wait loader, wait counter, ms counter) among `N_PLAYERS` buttons. Sequences `ROUNDS` rounds, awards each round to the first valid press after the stimulus, and reports the game champion. Sits above the datapath in place of the single-player control FSM.

## Interface
- `N_PLAYERS`, 4: number of player buttons, 2..8.
- `ROUNDS`, 5: rounds per game, ≥1.
- `MS_W`, 12: width of the ms count.
- `TIMEOUT_MS`, 2000: reaction window in ms; must be < 2^MS_W.

- `ck`  in  1  clock (rising edge).
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse; starts a game from IDLE or DONE, ignored otherwise.
- `pul`  in  N_PLAYERS  per-player press pulses, already synchronized and debounced, one cycle each.
- `zero`  in  1  datapath random-wait counter reached 0.
- `count_ms`  in  MS_W  datapath reaction counter.
- `load_rand`  out  1  pulse; datapath loads a new random wait.
- `clear_count_ms`  out  1  pulse; datapath clears `count_ms`.
- `count_enable`  out  1  level; datapath increments `count_ms` on each 1 ms tick while high.
- `led`  out  1  stimulus.
- `false_start`  out  N_PLAYERS  per-player disqualification flags for the current round.
- `winner_valid`  out  1  one-cycle round-result strobe.
- `no_winner`  out  1  qualifies `winner_valid`: round ended without a winner.
- `winner_id`  out  clog2(N_PLAYERS)  round winner.
- `winner_ms`  out  MS_W  winner's reaction time.
- `busy`  out  1  high outside IDLE/DONE.
- `game_done`  out  1  level in DONE.
- `champion`  out  clog2(N_PLAYERS)  valid while `game_done`.

## Operation
- States: IDLE, ARM, WAIT_RAND, REACT, SCORE, DONE.
- IDLE/DONE → ARM on `start`. Entry from either state clears the points registers and `round_cnt`.
- ARM, 1 cycle:
  - Pulse `load_rand` and `clear_count_ms`.
  - Clear `false_start`.
  - Go to WAIT_RAND.
- WAIT_RAND:
  - Any `pul[i]` sets `false_start[i]`, including a press in the same cycle as `zero`.
  - If all `false_start` bits are set (counting this cycle's presses), go to SCORE with `no_winner`.
  - Otherwise, `zero` → REACT.
- REACT:
  - `led` and `count_enable` are high.
  - Eligible presses are `pul & ~false_start`.
  - If any are eligible, the round-robin arbiter picks one grant.
  - Latch `winner_id` and the `count_ms` value sampled in that cycle, then go to SCORE.
  - If there are no eligible presses and `count_ms ≥ TIMEOUT_MS`, go to SCORE with `no_winner`.
- SCORE, 1 cycle:
  - Assert `winner_valid`.
  - On a win, increment `points[winner_id]` and set the round-robin pointer to `winner_id+1` (mod N).
  - Increment `round_cnt`.
  - If `round_cnt` reaches `ROUNDS`, go to DONE; else go to ARM.
- DONE:
  - `champion` = player with the most points; ties go to the lowest index.
  - Registered on entry and held.
- Points width is clog2(ROUNDS+1) and saturates. `round_cnt` width is clog2(ROUNDS+1).
- `start` in any busy state is ignored.
- Presses in ARM, SCORE, IDLE and DONE are ignored.

## Timing
- Reset values: state IDLE, all outputs 0, points 0, round-robin pointer 0, `round_cnt` 0.
- Reset mid-game aborts immediately; no `winner_valid` is emitted.
- `start` in cycle t → `load_rand`/`clear_count_ms` in t+1.
- `zero` in cycle t → `led`/`count_enable` high from t+1.
- Press in cycle t (REACT):
  - `winner_valid` in t+1.
  - `led`/`count_enable` low from t+1.
  - `winner_ms` = `count_ms` at t.
- `winner_id`/`winner_ms`/`no_winner` hold until the next SCORE.
- `false_start` holds until the next ARM.
- Last SCORE at cycle t → `game_done` and `champion` valid from t+1.
- All outputs are registered; no combinational input-to-output paths.

## Structure
- Package `reflex_pkg` holds:
  - the state enum;
  - player-ID and points width helper functions;
  - the default `N_PLAYERS`/`ROUNDS`/`TIMEOUT_MS` constants.
- Sub-module `rr_arbiter`:
  - Inputs: `N_PLAYERS` request vector and pointer.
  - Outputs: one-hot grant plus encoded index.
  - Purely combinational.
- Points, pointer and FSM stay in `reflex_arbiter`.

## Test plan
- Basic round: N=4, ROUNDS=1. `start`, `zero` after 10 cycles, `pul[2]` with `count_ms`=137 → `winner_valid`, `winner_id`=2, `winner_ms`=137, `game_done`, `champion`=2.
- Simultaneous press: pointer 0 and `pul`=4'b1010 → winner 1. Next round `pul`=4'b1010 → winner 3 (pointer now 2).
- False start: `pul[0]` in WAIT_RAND, including the `zero` cycle → `false_start`=4'b0001. `pul[0]` in REACT is ignored; `pul[3]` wins.
- All false-start and timeout:
  - All four press before `zero` → `no_winner` strobe, no REACT.
  - Separately, no press until `count_ms`=2000 → `no_winner`.
  - In both cases `round_cnt` advances.
- Champion tie and reset: ROUNDS=4, wins 1,2,1,2 → `champion`=1. `reset_n` low mid-REACT → all outputs 0, IDLE, points cleared.

Source files
------------

// File: rtl/reflex_pkg.sv
// Shared types and sizing helpers for the multi-player reflex round scheduler.
package reflex_pkg;

  localparam int unsigned DefNPlayers  = 4;
  localparam int unsigned DefRounds    = 5;
  localparam int unsigned DefMsW       = 12;
  localparam int unsigned DefTimeoutMs = 2000;

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StWaitRand,
    StReact,
    StScore,
    StDone
  } state_e;

  function automatic int unsigned id_width(int unsigned n_players);
    return (n_players > 1) ? $clog2(n_players) : 1;
  endfunction

  function automatic int unsigned pts_width(int unsigned rounds);
    return (rounds > 0) ? $clog2(rounds + 1) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first request at or after ptr_i (wrapping) wins.
module rr_arbiter #(
  parameter int unsigned N   = 4,
  parameter int unsigned IdW = 2
) (
  input  logic [N-1:0]   req_i,
  input  logic [IdW-1:0] ptr_i,
  output logic [N-1:0]   gnt_o,
  output logic [IdW-1:0] gnt_idx_o
);

  localparam int unsigned SumW = IdW + 1;

  logic [2*N-1:0] req_dbl;
  logic [N-1:0]   req_rot;
  logic [SumW-1:0] sum;
  logic           found;

  // Rotating right by the pointer puts the highest-priority request at bit 0.
  assign req_dbl = {req_i, req_i} >> ptr_i;
  assign req_rot = req_dbl[N-1:0];

  always_comb begin
    found     = 1'b0;
    sum       = '0;
    gnt_idx_o = '0;
    for (int k = 0; k < N; k++) begin
      if (!found && req_rot[k]) begin
        found = 1'b1;
        sum   = {1'b0, ptr_i} + SumW'(k);
        if (sum >= SumW'(N)) begin
          sum = sum - SumW'(N);
        end
        gnt_idx_o = sum[IdW-1:0];
      end
    end
    gnt_o = found ? (N'(1) << gnt_idx_o) : '0;
  end

endmodule

// File: rtl/reflex_arbiter.sv
// Multi-player round scheduler sharing one reaction-timing datapath among N_PLAYERS buttons.
module reflex_arbiter
  import reflex_pkg::*;
#(
  parameter int unsigned N_PLAYERS  = DefNPlayers,
  parameter int unsigned ROUNDS     = DefRounds,
  parameter int unsigned MS_W       = DefMsW,
  parameter int unsigned TIMEOUT_MS = DefTimeoutMs,
  localparam int unsigned IdW       = id_width(N_PLAYERS)
) (
  input  logic                 ck,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [N_PLAYERS-1:0] pul,
  input  logic                 zero,
  input  logic [MS_W-1:0]      count_ms,
  output logic                 load_rand,
  output logic                 clear_count_ms,
  output logic                 count_enable,
  output logic                 led,
  output logic [N_PLAYERS-1:0] false_start,
  output logic                 winner_valid,
  output logic                 no_winner,
  output logic [IdW-1:0]       winner_id,
  output logic [MS_W-1:0]      winner_ms,
  output logic                 busy,
  output logic                 game_done,
  output logic [IdW-1:0]       champion
);

  localparam int unsigned PtsW = pts_width(ROUNDS);

  state_e state_q, state_d;

  logic [N_PLAYERS-1:0][PtsW-1:0] points_q, points_d;
  logic [IdW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [PtsW-1:0]      round_cnt_q, round_cnt_d;
  logic [N_PLAYERS-1:0] false_start_q, false_start_d;
  logic [IdW-1:0]       winner_id_q, winner_id_d;
  logic [MS_W-1:0]      winner_ms_q, winner_ms_d;
  logic                 no_winner_q, no_winner_d;
  logic                 winner_valid_q, winner_valid_d;
  logic                 arm_q, arm_d;
  logic                 led_q, led_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [IdW-1:0]       champion_q, champion_d;

  logic [N_PLAYERS-1:0] eligible;
  logic [N_PLAYERS-1:0] fs_seen;
  logic [N_PLAYERS-1:0] gnt;
  logic [IdW-1:0]       gnt_idx;
  logic [PtsW-1:0]      best_pts;
  logic [IdW-1:0]       best_id;

  assign eligible = pul & ~false_start_q;
  assign fs_seen  = false_start_q | pul;

  rr_arbiter #(
    .N   (N_PLAYERS),
    .IdW (IdW)
  ) u_rr_arbiter (
    .req_i     (eligible),
    .ptr_i     (rr_ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  always_comb begin
    state_d       = state_q;
    points_d      = points_q;
    rr_ptr_d      = rr_ptr_q;
    round_cnt_d   = round_cnt_q;
    false_start_d = false_start_q;
    winner_id_d   = winner_id_q;
    winner_ms_d   = winner_ms_q;
    no_winner_d   = no_winner_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d     = StArm;
          points_d    = '0;
          round_cnt_d = '0;
        end
      end
      StArm: begin
        false_start_d = '0;
        state_d       = StWaitRand;
      end
      StWaitRand: begin
        // A press coinciding with zero still counts as a false start.
        false_start_d = fs_seen;
        if (&fs_seen) begin
          no_winner_d = 1'b1;
          state_d     = StScore;
        end else if (zero) begin
          state_d = StReact;
        end
      end
      StReact: begin
        if (|gnt) begin
          winner_id_d = gnt_idx;
          winner_ms_d = count_ms;
          no_winner_d = 1'b0;
          state_d     = StScore;
        end else if (count_ms >= MS_W'(TIMEOUT_MS)) begin
          no_winner_d = 1'b1;
          state_d     = StScore;
        end
      end
      StScore: begin
        if (!no_winner_q) begin
          if (points_q[winner_id_q] != {PtsW{1'b1}}) begin
            points_d[winner_id_q] = points_q[winner_id_q] + 1'b1;
          end
          rr_ptr_d = (winner_id_q == IdW'(N_PLAYERS - 1)) ? '0 : winner_id_q + 1'b1;
        end
        round_cnt_d = round_cnt_q + 1'b1;
        state_d     = (round_cnt_d == PtsW'(ROUNDS)) ? StDone : StArm;
      end
      default: state_d = StIdle;
    endcase
  end

  // Strict greater-than keeps ties on the lowest index.
  always_comb begin
    best_pts = points_d[0];
    best_id  = '0;
    for (int i = 1; i < N_PLAYERS; i++) begin
      if (points_d[i] > best_pts) begin
        best_pts = points_d[i];
        best_id  = IdW'(i);
      end
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_comb begin
    arm_d          = (state_d == StArm);
    led_d          = (state_d == StReact);
    winner_valid_d = (state_d == StScore);
    busy_d         = !(state_d inside {StIdle, StDone});
    done_d         = (state_d == StDone);
    champion_d     = champion_q;
    if (state_q == StScore && state_d == StDone) begin
      champion_d = best_id;
    end
  end

  always_ff @(posedge ck or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= StIdle;
      points_q       <= '0;
      rr_ptr_q       <= '0;
      round_cnt_q    <= '0;
      false_start_q  <= '0;
      winner_id_q    <= '0;
      winner_ms_q    <= '0;
      no_winner_q    <= 1'b0;
      winner_valid_q <= 1'b0;
      arm_q          <= 1'b0;
      led_q          <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      champion_q     <= '0;
    end else begin
      state_q        <= state_d;
      points_q       <= points_d;
      rr_ptr_q       <= rr_ptr_d;
      round_cnt_q    <= round_cnt_d;
      false_start_q  <= false_start_d;
      winner_id_q    <= winner_id_d;
      winner_ms_q    <= winner_ms_d;
      no_winner_q    <= no_winner_d;
      winner_valid_q <= winner_valid_d;
      arm_q          <= arm_d;
      led_q          <= led_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      champion_q     <= champion_d;
    end
  end

  assign load_rand      = arm_q;
  assign clear_count_ms = arm_q;
  assign count_enable   = led_q;
  assign led            = led_q;
  assign false_start    = false_start_q;
  assign winner_valid   = winner_valid_q;
  assign no_winner      = no_winner_q;
  assign winner_id      = winner_id_q;
  assign winner_ms      = winner_ms_q;
  assign busy           = busy_q;
  assign game_done      = done_q;
  assign champion       = champion_q;

endmodule
